// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFim
    } div_state_e;

    localparam int unsigned DefaultWidth    = 8;
    localparam int unsigned DefaultCntWidth = $clog2(DefaultWidth + 1);

    // Iteration counter must hold values up to the operand width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/subtrator_n.sv
// Combinational N-bit subtractor a - b computed as a + ~b + 1; cout_o=1 means no borrow.
module subtrator_n #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         cout_o
);

    assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + (N + 1)'(1);

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential unsigned restoring divider: one quotient bit per clock, done pulse on completion.
module divisor_sequencial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    import div_pkg::*;

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_e       state_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   r_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [WIDTH:0]   p;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic             unused_r_msb;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign p = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    subtrator_n #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i   (p),
        .b_i   ({1'b0, d_q}),
        .diff_o(diff),
        .cout_o(no_borrow)
    );

    assign r_d          = no_borrow ? diff : p;
    assign q_d          = {q_q[WIDTH-2:0], no_borrow};
    assign unused_r_msb = r_q[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (divisor != '0) begin
                            d_q     <= divisor;
                            q_q     <= dividendo;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            dz_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= StCalc;
                        end else begin
                            quo_q   <= '1;
                            rem_q   <= dividendo;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StFim;
                        end
                    end
                end
                StCalc: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        quo_q   <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFim;
                    end
                end
                StFim: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign quociente = quo_q;
    assign resto     = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial: directed corner cases plus back-to-back random ops.
module tb_divisor_sequencial;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividendo = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quociente;
    logic [W-1:0] resto;
    logic         busy;
    logic         done;
    logic         div_zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_done = -1;
    bit   gap_chk = 1'b0;
    exp_t sb[$];

    divisor_sequencial #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividendo(dividendo),
        .divisor  (divisor),
        .quociente(quociente),
        .resto    (resto),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain unsigned division; divide-by-zero saturates quotient and passes dividend.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = {W{1'b1}};
            e.r  = W'(a);
            e.dz = 1'b1;
        end else begin
            e.q  = W'(a / b);
            e.r  = W'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT signals done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && done) check("busy_done_overlap", 32'(busy & done), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quociente", 32'(quociente), 32'(e.q));
                    check("resto", 32'(resto), 32'(e.r));
                    check("div_zero", 32'(div_zero), 32'(e.dz));
                end
                if (gap_chk && last_done >= 0) check("done_spacing", cyc - last_done, W + 2);
                last_done = cyc;
            end
        end
    end

    // Issue one op just after a clock edge with the DUT idle; returns just after an edge, idle again.
    task automatic run_op(input int a, input int b, input bit poke);
        int n;
        dividendo = W'(a);
        divisor   = W'(b);
        start     = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividendo = W'($urandom);
        divisor   = W'($urandom);
        check("busy_after_start", 32'(busy), 32'(b != 0));
        n = 0;
        while (!done && n < 40) begin
            if (poke && n == 3) begin
                start     = 1'b1;
                dividendo = W'(50);
                divisor   = W'(5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, (b == 0) ? 0 : W);
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int a;
        int b;
        #1;
        check("rst_quociente", 32'(quociente), 32'd0);
        check("rst_resto", 32'(resto), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(100, 7, 1'b0);
        run_op(255, 1, 1'b0);
        run_op(7, 9, 1'b0);
        run_op(200, 200, 1'b0);
        run_op(0, 5, 1'b0);
        run_op(5, 0, 1'b0);
        run_op(9, 3, 1'b0);
        run_op(100, 7, 1'b1);

        // Reset in the middle of an operation drops it without a done pulse.
        dividendo = 8'd100;
        divisor   = 8'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_quociente", 32'(quociente), 32'd0);
        check("midrst_resto", 32'(resto), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_div_zero", 32'(div_zero), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        run_op(64, 32, 1'b0);

        // Back-to-back random ops with start held high.
        gap_chk   = 1'b1;
        last_done = -1;
        start     = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 3));
            dividendo = W'(a);
            divisor   = W'(b);
            sb.push_back(model(a, b));
            @(posedge clk);
            #1;
            if (k == 999) start = 1'b0;
            repeat (W + 1) @(posedge clk);
            #1;
        end
        for (int t = 0; t < 50 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        gap_chk = 1'b0;
        check("scoreboard_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
